serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous and active-low, sampled on rising clk.
REQ-004 Port: start  input  1  request to begin an addition; sampled only when the block is accepting.
REQ-005 Port: a  input  WIDTH  operand A; captured on the accepting edge.
REQ-006 Port: b  input  WIDTH  operand B; captured on the accepting edge.
REQ-007 Port: cin  input  1  carry-in; captured on the accepting edge.
REQ-008 Port: busy  output  1  high while bits are being processed (RUN state).
REQ-009 Port: done  output  1  one-cycle pulse marking sum/cout valid and updated.
REQ-010 Port: sum  output  WIDTH  registered result; held between completions.
REQ-011 Port: cout  output  1  registered carry-out; held between completions.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 Accepting means state IDLE or DONE; start=1 on an accepting edge SHALL load a and b into LSB-first shift registers, load the carry flop with cin, clear the bit counter and enter RUN.
REQ-014 Each RUN edge SHALL add shift-A bit 0, shift-B bit 0 and the carry flop through one 1-bit full-adder slice.
REQ-015 On that edge, the slice sum bit SHALL shift into the MSB of a partial-sum register, the operand registers SHALL shift right, the carry flop SHALL take the slice carry and the counter SHALL increment.
REQ-016 On the RUN edge with counter == WIDTH-1, the block SHALL copy the completed partial sum to sum and the final carry to cout, and enter DONE.
REQ-017 Latency: with start accepted at edge 0, sum and cout SHALL be updated at edge WIDTH, and done SHALL be high for exactly the cycle following edge WIDTH.
REQ-018 DONE SHALL last one cycle, then go to IDLE; if start=1 in DONE, it SHALL go directly to RUN (back-to-back, no idle gap).
REQ-019 start SHALL be ignored while in RUN; operands and results SHALL be unaffected.
REQ-020 a, b and cin SHALL be don't-care except on accepting edges.
REQ-021 sum and cout SHALL change only on the completion edge or on reset; intermediate partial sums SHALL never be visible on outputs.
REQ-022 Arithmetic: {cout,sum} SHALL equal a + b + cin modulo 2^(WIDTH+1); no overflow flag.
REQ-023 busy SHALL be 1 in RUN and 0 in IDLE and DONE; done SHALL be 1 only in DONE.

Reset
REQ-024 rst_n=0 on a rising edge SHALL force state IDLE and clear the counter, carry flop, shift registers, sum, cout, busy and done to 0, overriding start.
REQ-025 Reset asserted during RUN SHALL abort the addition; no done pulse SHALL follow, and sum/cout SHALL read 0.
REQ-026 The first start SHALL be honoured on the first edge with rst_n=1.

Structure
REQ-027 A shared package serial_adder_pkg SHALL hold the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH.
REQ-028 The counter width SHALL be derived from WIDTH as ceil(log2(WIDTH)) bits.
REQ-029 Exactly one sub-module, sa_bit_slice, SHALL be used: a combinational 1-bit full adder (a, b, cin -> sum, cout), instantiated once.

Verification
REQ-030 WIDTH=8, a=0x5A, b=0x33, cin=0, start pulse -> busy for 8 cycles, done pulse in cycle 9, sum=0x8D, cout=0.
REQ-031 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-032 start=1 held with a=0x10, b=0x20, then operands changed to 0x77 and 0x11 mid-RUN -> sum=0x30, cout=0; exactly one done pulse per accepted start.
REQ-033 start asserted in the DONE cycle with a=0x01, b=0x02 -> next sum=0x03, done again 9 cycles later; previous result held until then.
REQ-034 rst_n=0 at RUN bit 4 -> busy=0, done never pulses, sum=0x00, cout=0; next start completes normally.
REQ-035 Randomized self-check over 1000 operand pairs against a + b + cin -> zero mismatches.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared state encoding and default width for the bit-serial
//               adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sa_bit_slice.sv
// ============================================================================
// Module      : sa_bit_slice
// Description : Combinational 1-bit full adder slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sa_bit_slice (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module      : serial_adder
// Description : LSB-first bit-serial adder, one bit per clock, with a
//               one-cycle done pulse and held registered result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-2:0] psum_q, psum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] psum_full;

    sa_bit_slice u_slice (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Partial sum including the bit produced this cycle; complete on the last bit.
    assign psum_full = {slice_sum, psum_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        psum_d  = psum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                psum_d  = psum_full[WIDTH-1:1];
                carry_d = slice_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = psum_full;
                    cout_d  = slice_cout;
                    state_d = DONE;
                end
            end
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            psum_q  <= psum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module      : tb_serial_adder
// Description : Scoreboard bench for serial_adder (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int           checks = 0;
    int           errors = 0;
    logic [W:0]   sb[$];
    logic [W:0]   last_res = '0;
    logic         mon_en   = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse; result must otherwise hold.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (busy === 1'b1 && done === 1'b1) begin
                    checks++; errors++;
                    $display("FAIL busy_done_overlap: busy=%b done=%b", busy, done);
                end
                if (done === 1'b1) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done: got result 0x%0h with empty scoreboard", {cout, sum});
                    end else begin
                        check("result", {23'd0, cout, sum}, {23'd0, sb.pop_front()});
                    end
                    last_res = {cout, sum};
                end else if (rst_n === 1'b0) begin
                    last_res = {cout, sum};
                end else if ({cout, sum} !== last_res) begin
                    checks++; errors++;
                    $display("FAIL result_hold: got 0x%0h expected 0x%0h", {cout, sum}, last_res);
                    last_res = {cout, sum};
                end
            end
        end
    end

    // Drives one start pulse at the current negedge; returns at the next negedge.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        a     = ta;
        b     = tb;
        cin   = tc;
        start = 1'b1;
        sb.push_back({1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc});
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        cin   = $urandom_range(0, 1);
    endtask

    // Counts cycles (from the cycle after the accepting edge) until done is seen.
    task automatic wait_done(output int busy_cyc, output int cyc);
        busy_cyc = 0;
        cyc      = 1;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) busy_cyc++;
            @(negedge clk);
            cyc++;
        end
        if (done !== 1'b1) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done within %0d cycles, expected done", cyc);
        end
    endtask

    initial begin
        int bc, cy;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);

        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_sum",  {24'd0, sum},  32'd0);
        check("reset_cout", {31'd0, cout}, 32'd0);

        // First start on the very first edge with reset released.
        rst_n = 1'b1;
        issue(8'h5A, 8'h33, 1'b0);
        wait_done(bc, cy);
        check("busy_cycles", bc, 32'd8);
        check("done_cycle",  cy, 32'd9);
        check("sum_5A_33",   {23'd0, cout, sum}, 32'h08D);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);

        issue(8'hFF, 8'h01, 1'b0);
        wait_done(bc, cy);
        check("sum_FF_01", {23'd0, cout, sum}, 32'h100);
        @(negedge clk);

        issue(8'hFF, 8'hFF, 1'b1);
        wait_done(bc, cy);
        check("sum_FF_FF_1", {23'd0, cout, sum}, 32'h1FF);
        @(negedge clk);

        // start held and operands changed while running.
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        sb.push_back(9'h030);
        @(negedge clk);
        a = 8'h77; b = 8'h11;
        repeat (4) @(negedge clk);
        start = 1'b0;
        wait_done(bc, cy);
        check("held_start_sum", {23'd0, cout, sum}, 32'h030);

        // Back-to-back start in the DONE cycle.
        issue(8'h01, 8'h02, 1'b0);
        check("b2b_prev_held", {23'd0, cout, sum}, 32'h030);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done(bc, cy);
        check("b2b_done_cycle", cy, 32'd9);
        check("b2b_sum", {23'd0, cout, sum}, 32'h003);
        @(negedge clk);

        // Reset in the middle of a run aborts it.
        issue(8'h5A, 8'h33, 1'b0);
        repeat (3) @(negedge clk);
        void'(sb.pop_back());
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_res",  {23'd0, cout, sum}, 32'd0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_done_res", {23'd0, cout, sum}, 32'd0);
        issue(8'hA5, 8'h5B, 1'b1);
        wait_done(bc, cy);
        check("after_abort_sum", {23'd0, cout, sum}, 32'h101);
        @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
            wait_done(bc, cy);
            if (i % 2 == 0) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
